// File: rtl/wb_data_ram.sv
// Wishbone-classic responder RAM with programmable wait states before a single-cycle ack.
// Byte lanes are big-endian: sel[3] -> bits 31:24, sel[0] -> bits 7:0.
module wb_data_ram #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o
);
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WC_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       dat;
  } req_t;

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       go_ack;
  req_t       req_in, req_q, req_cur;
  logic       req_v;

  logic [3:0][7:0] mem [DEPTH];

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  assign req_v  = wb_cyc_i & wb_stb_i;
  assign req_in = '{we: wb_we_i, sel: wb_sel_i, idx: wb_adr_i[ADDR_W+1:2], dat: wb_dat_i};
  // With zero wait states the commit edge is the sampling edge, so use the live bus.
  assign req_cur = (state == IDLE) ? req_in : req_q;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    go_ack    = 1'b0;
    case (state)
      IDLE: if (req_v) begin
        if (WAIT_CYCLES == 0) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
        end else begin
          state_nxt = WAIT;
          wcnt_nxt  = WC_INIT;
        end
      end
      WAIT: begin
        if (!wb_cyc_i)        state_nxt = IDLE;
        else if (wcnt == '0) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
        end else              wcnt_nxt = wcnt - 4'd1;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      wb_ack_o <= go_ack;
      wb_dat_o <= (go_ack && !req_cur.we) ? 32'(mem[req_cur.idx]) : 32'd0;
    end
  end

  always_ff @(posedge clk)
    if (state == IDLE && req_v) req_q <= req_in;

  // Storage has no reset; a reset edge still blocks the pending commit.
  always_ff @(posedge clk)
    if (!rst && go_ack && req_cur.we)
      for (int l = 0; l < 4; l++)
        if (req_cur.sel[l]) mem[req_cur.idx][l] <= req_cur.dat[8*l +: 8];

endmodule

// File: doc/wb_data_ram.md
# wb_data_ram

Wishbone-classic responder RAM for the yangMIPS SOPC data bus. It services single read/write cycles issued by the CPU's data-memory initiator. It inserts a configurable number of wait states before acknowledging. The block sits in `yangmips_min_sopc` between the CPU data port and on-chip storage, and gives the pipeline a real stall-inducing memory in place of a zero-latency array.

## Interface
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: wait states inserted before ack; legal range 0..15.

- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `wb_cyc_i`  in  1: bus cycle in progress.
- `wb_stb_i`  in  1: strobe; request valid when `wb_cyc_i & wb_stb_i`.
- `wb_we_i`  in  1: 1 = write, 0 = read.
- `wb_adr_i`  in  32: byte address; word index = `wb_adr_i[ADDR_W+1:2]`. Bits [1:0] and bits above ADDR_W+1 are ignored (aliasing).
- `wb_sel_i`  in  4: byte-lane enables, big-endian MIPS order. sel[3] maps to bits 31:24 and sel[0] maps to bits 7:0.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data.
- `wb_ack_o`  out  1: single-cycle acknowledge.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE:** on an edge where `cyc & stb` is high, latch adr, we, sel and dat_i.
  - If WAIT_CYCLES = 0, go to ACK.
  - Otherwise go to WAIT with `wcnt = WAIT_CYCLES-1`.
- **WAIT:**
  - If `wb_cyc_i` is low on an edge: abort and return to IDLE. No write occurs and no ack is issued.
  - Else if `wcnt = 0`: go to ACK.
  - Else: decrement `wcnt`.
- **Entering ACK (the edge of the IDLE→ACK or WAIT→ACK transition):**
  - Write: update only the lanes whose latched sel bit is 1. Other lanes keep their old value. `wb_dat_o` is loaded with 0.
  - Read: `wb_dat_o` is loaded with the full addressed word, regardless of sel.
  - `wb_ack_o` is set to 1.
- **ACK:** lasts exactly one cycle and returns to IDLE unconditionally. On exit, `wb_ack_o` goes to 0 and `wb_dat_o` goes to 0. Requests present during the ACK cycle are not sampled; the earliest next sample is the edge ending the following IDLE cycle.
- Latched request fields are used throughout. Input changes after the request is accepted have no effect.
- Memory array is not reset; its contents are undefined until written.
- Same-address read after write returns the newly written lanes.

## Timing
- Reset (`rst` high at an edge):
  - state → IDLE, `wcnt` → 0, `wb_ack_o` → 0, `wb_dat_o` → 0.
  - A write that would have committed on that edge is suppressed.
  - Reset during WAIT or ACK abandons the transaction; no ack follows.
- Latency: request sampled at the edge ending cycle 0 → `wb_ack_o` high during cycle 1+WAIT_CYCLES, for exactly one cycle.
- Throughput: one transaction per 2+WAIT_CYCLES cycles with the request held continuously.
- `wb_dat_o` is valid only while `wb_ack_o` is high during a read, and is 0 at all other times.
- `wb_stb_i` dropping during WAIT while `wb_cyc_i` stays high does not abort the transaction.

## Test plan
- **Reset values:** hold `rst` for 10 cycles with stb asserted → `ack_o` = 0 and `dat_o` = 0 throughout; the first ack comes only after `rst` is released.
- **Full-word write/read, WAIT_CYCLES=1:**
  - Write 0xDEADBEEF, sel=4'hF, to adr 0x0000_0010 → ack in cycle 2 after sampling.
  - Read from adr 0x0000_0010 → `dat_o` = 0xDEADBEEF during the single ack cycle, and 0 on the next cycle.
- **Byte lanes:**
  - Write 0x11223344 with sel=F, then 0xAABBCCDD with sel=4'b1010, to adr 0x20.
  - Read adr 0x20 → 0xAA22CC44.
  - Read adr 0x23 (misaligned alias of the same word) → 0xAA22CC44.
- **Latency sweep:** WAIT_CYCLES = 0, 3, 15 → ack in cycle 1, 4, 16 respectively. Back-to-back requests with stb held → ack spacing of 2, 5, 17 cycles.
- **Abort:** WAIT_CYCLES=3; start a write of 0x5555AAAA to adr 0x40 (previous contents 0x0); drop `cyc` in the second WAIT cycle → no ack, and a subsequent read returns 0x0.
- **Reset mid-operation and aliasing:**
  - Assert `rst` in the ACK-entry cycle of a write → no ack, and the word is unchanged.
  - With ADDR_W=10, write 0x12345678 at adr 0x0000_1004 → a read at adr 0x0000_0004 returns 0x12345678.
